// File: rtl/read_seq_ctrl_pkg.sv
// Shared MMU definitions: read-sequencer FSM encoding and the generator mode bit-fields.
package read_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

    // Mode field layout as decoded by the address generator.
    localparam int unsigned ModeConvBit    = 0;
    localparam int unsigned ModePoolBit    = 1;
    localparam int unsigned ModeStrideLsb  = 2;
    localparam int unsigned ModeStrideMsb  = 3;
    localparam int unsigned ModeTransBit   = 4;

endpackage

// File: rtl/read_seq_ctrl.sv
// Read-job sequencer: clears the address generator, steps it through num_rows rows and
// reports completion; abort cancels from any state and stall freezes generator advance.
module read_seq_ctrl
    import read_seq_ctrl_pkg::*;
#(
    parameter int unsigned DIM_OUTPUT_NEURONS = 8,
    parameter int unsigned DIM_MODE           = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DIM_MODE-1:0]           mode_in,
    input  logic [DIM_OUTPUT_NEURONS-1:0] num_rows,
    input  logic                          use_stack_in,
    input  logic                          stall,
    input  logic                          valid_data,
    output logic                          gen_en,
    output logic                          gen_clr,
    output logic [DIM_MODE-1:0]           mode,
    output logic                          use_stack,
    output logic                          rd_strobe,
    output logic [DIM_OUTPUT_NEURONS-1:0] row_idx,
    output logic                          busy,
    output logic                          done
);

    localparam logic [DIM_OUTPUT_NEURONS-1:0] RowOne = DIM_OUTPUT_NEURONS'(1);

    seq_state_e                    state_q, state_d;
    logic [DIM_OUTPUT_NEURONS-1:0] row_idx_q, row_idx_d;
    logic [DIM_OUTPUT_NEURONS-1:0] rows_q, rows_d;
    logic [DIM_MODE-1:0]           mode_q, mode_d;
    logic                          use_stack_q, use_stack_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            row_idx_q   <= '0;
            rows_q      <= '0;
            mode_q      <= '0;
            use_stack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            rows_q      <= rows_d;
            mode_q      <= mode_d;
            use_stack_q <= use_stack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        rows_d      = rows_q;
        mode_d      = mode_q;
        use_stack_d = use_stack_q;
        gen_en      = 1'b0;
        gen_clr     = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with abort is dropped.
                if (start && !abort) begin
                    rows_d      = num_rows;
                    mode_d      = mode_in;
                    use_stack_d = use_stack_in;
                    row_idx_d   = '0;
                    state_d     = StClear;
                end
            end
            StClear: begin
                gen_clr = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (rows_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    gen_clr = 1'b1;
                    state_d = StIdle;
                end else begin
                    gen_en = !stall;
                    // valid_data only counts while the generator is actually enabled.
                    if (valid_data && !stall) begin
                        if (row_idx_q == rows_q - RowOne) begin
                            state_d = StDone;
                        end else begin
                            row_idx_d = row_idx_q + RowOne;
                        end
                    end
                end
            end
            StDone: begin
                gen_clr = 1'b1;
                done    = !abort;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rd_strobe = gen_en;
    assign busy      = (state_q != StIdle);
    assign row_idx   = row_idx_q;
    assign mode      = mode_q;
    assign use_stack = use_stack_q;

endmodule

// File: tb/tb_read_seq_ctrl.sv
// Self-checking bench for read_seq_ctrl: directed job scenarios plus randomized traffic
// checked every cycle against a job-level behavioural model.
module tb_read_seq_ctrl;

    localparam int unsigned N = 8;
    localparam int unsigned M = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [M-1:0] mode_in = '0;
    logic [N-1:0] num_rows = '0;
    logic         use_stack_in = 1'b0;
    logic         stall = 1'b0;
    logic         valid_data = 1'b0;
    logic         gen_en, gen_clr, use_stack, rd_strobe, busy, done;
    logic [M-1:0] mode;
    logic [N-1:0] row_idx;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int done_count = 0;

    read_seq_ctrl #(
        .DIM_OUTPUT_NEURONS(N),
        .DIM_MODE          (M)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mode_in     (mode_in),
        .num_rows    (num_rows),
        .use_stack_in(use_stack_in),
        .stall       (stall),
        .valid_data  (valid_data),
        .gen_en      (gen_en),
        .gen_clr     (gen_clr),
        .mode        (mode),
        .use_stack   (use_stack),
        .rd_strobe   (rd_strobe),
        .row_idx     (row_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job is active from accepted start until it finishes or is aborted.
    // It spends one cycle clearing, then counts rows, then one cycle finishing.
    bit m_active, m_clearing, m_finishing, m_us;
    int m_row, m_rows, m_mode;

    initial begin
        m_active = 0; m_clearing = 0; m_finishing = 0; m_us = 0;
        m_row = 0; m_rows = 0; m_mode = 0;
    end

    function automatic bit exp_gen_en();
        return m_active && !m_clearing && !m_finishing && !stall && !abort;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_clearing = 0; m_finishing = 0; m_us = 0;
            m_row = 0; m_rows = 0; m_mode = 0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1; m_clearing = 1; m_row = 0;
                m_rows = int'(num_rows); m_mode = int'(mode_in); m_us = use_stack_in;
            end
        end else if (abort) begin
            m_active = 0; m_clearing = 0; m_finishing = 0;
        end else if (m_clearing) begin
            m_clearing = 0;
            if (m_rows == 0) m_finishing = 1;
        end else if (m_finishing) begin
            m_active = 0; m_finishing = 0;
        end else if (valid_data && !stall) begin
            if (m_row == m_rows - 1) m_finishing = 1;
            else m_row = m_row + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gen_en", 32'(gen_en), 32'(exp_gen_en()));
            check("rd_strobe", 32'(rd_strobe), 32'(exp_gen_en()));
            check("gen_clr", 32'(gen_clr),
                  32'(m_active && (m_clearing || m_finishing || abort)));
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_finishing && !abort));
            check("row_idx", 32'(row_idx), 32'(m_row));
            check("mode", 32'(mode), 32'(m_mode));
            check("use_stack", 32'(use_stack), 32'(m_us));
            if (done === 1'b1) done_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen_clr", 32'(gen_clr), 32'd0);
        check("rst_row_idx", 32'(row_idx), 32'd0);

        // Three-row job; start ignored during DONE
        start = 1'b1; num_rows = 8'd3; mode_in = 5'h15; use_stack_in = 1'b1;
        tick();
        start = 1'b0; num_rows = 8'd9; mode_in = 5'h02;
        check("t1_clr_c1", 32'(gen_clr), 32'd1);
        check("t1_busy_c1", 32'(busy), 32'd1);
        check("t1_en_c1", 32'(gen_en), 32'd0);
        tick();
        check("t1_en_c2", 32'(gen_en), 32'd1);
        check("t1_row0", 32'(row_idx), 32'd0);
        valid_data = 1'b1;
        tick();
        check("t1_row1", 32'(row_idx), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_row2", 32'(row_idx), 32'd2);
        check("t1_mode_held", 32'(mode), 32'h15);
        tick();
        valid_data = 1'b0;
        check("t1_done", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_idle_after_done", 32'(busy), 32'd0);
        check("t1_done_once", 32'(done), 32'd0);
        check("t1_done_count", 32'(done_count), 32'd1);

        // Zero-row job
        start = 1'b1; num_rows = 8'd0;
        tick();
        start = 1'b0;
        tick();
        check("t2_done_c2", 32'(done), 32'd1);
        check("t2_no_en", 32'(gen_en), 32'd0);
        tick();

        // Stall mid-row with valid_data pulses
        start = 1'b1; num_rows = 8'd3;
        tick();
        start = 1'b0;
        tick();
        valid_data = 1'b1;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_stall_en", 32'(gen_en), 32'd0);
            tick();
            check("t3_stall_row", 32'(row_idx), 32'd1);
        end
        stall = 1'b0;
        tick();
        valid_data = 1'b0;
        check("t3_row_after", 32'(row_idx), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort coincident with final valid_data, then a fresh start
        start = 1'b1; num_rows = 8'd1;
        tick();
        start = 1'b0;
        tick();
        valid_data = 1'b1; abort = 1'b1;
        #1;
        check("t4_abort_clr", 32'(gen_clr), 32'd1);
        check("t4_abort_en", 32'(gen_en), 32'd0);
        check("t4_abort_done", 32'(done), 32'd0);
        tick();
        valid_data = 1'b0; abort = 1'b0;
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_no_done", 32'(done), 32'd0);
        start = 1'b1; num_rows = 8'd2;
        tick();
        start = 1'b0;
        check("t4_restart", 32'(gen_clr), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset mid-RUN at row 5
        start = 1'b1; num_rows = 8'd10; mode_in = 5'h1f;
        tick();
        start = 1'b0;
        tick();
        valid_data = 1'b1;
        repeat (5) tick();
        valid_data = 1'b0;
        check("t5_row5", 32'(row_idx), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_row", 32'(row_idx), 32'd0);
        check("t5_rst_mode", 32'(mode), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 599) == 0);
            start        = ($urandom_range(0, 5) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            valid_data   = ($urandom_range(0, 2) == 0);
            num_rows     = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            mode_in      = 5'($urandom);
            use_stack_in = 1'($urandom_range(0, 1));
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
